echo_avg_capture: RTL and testbench
===================================

Name: echo_avg_capture

Overview:
- Sits directly downstream of adControl and consumes its 14-bit sample stream (dout/doutEn) in the rclk_200m domain.
- On each external sync trigger it waits a programmable delay, then captures a window of samples.
- It coherently accumulates the window over a programmable number of shots in an internal RAM, then streams the summed record out over a valid/ready interface toward the MCU/SPI readout path.

Parameters:
- DW, 14, ADC sample width (signed two's complement)
- AW, 12, RAM address width; maximum window = 2^AW samples
- AVG_W, 8, shot-count width; up to 2^AVG_W shots
- ACC_W, DW+AVG_W, accumulator/output width (signed)
- DLY_W, 16, trigger-delay counter width

Ports:
- clk, in, 1, sample clock (rclk_200m)
- rst, in, 1, synchronous reset, active-high
- din, in, DW, sample from adControl dout
- din_en, in, 1, sample valid (adControl doutEn)
- trig_in, in, 1, raw SYNC_DIN, asynchronous
- cfg_start, in, 1, one-cycle pulse: latch config and arm
- cfg_delay, in, DLY_W, valid samples to skip after trigger
- cfg_len, in, AW+1, window length in samples (1..2^AW)
- cfg_navg, in, AVG_W+1, shots to accumulate (1..2^AVG_W)
- m_data, out, ACC_W, accumulated sample
- m_valid, out, 1, m_data valid
- m_ready, in, 1, consumer accepts
- m_last, out, 1, marks final word of record
- busy, out, 1, high in any state except IDLE
- done, out, 1, one-cycle pulse when the last word is accepted
- trig_miss, out, 1, sticky: a trigger edge arrived while in DELAY or CAPTURE

Behaviour:
- Reset: state IDLE. m_valid, m_last, busy, done and trig_miss are 0. m_data is 0. RAM contents are not cleared and need not be.
- Trigger handling:
  - trig_in passes through a 2-FF synchronizer, then rising-edge detection.
  - The edge is usable 3 cycles after the pin edge.
- Start:
  - cfg_start is honoured only in IDLE; it is ignored otherwise.
  - Start with cfg_len==0 or cfg_len>2^AW is ignored (stay IDLE).
  - cfg_navg==0 is treated as 1.
  - On an accepted start, config is latched, shot_cnt=0, trig_miss cleared, and the state goes to ARM.
- ARM: wait for a trigger edge, then go to DELAY with dly_cnt=0. din is ignored in this state.
- DELAY:
  - Counts din_en beats until dly_cnt==cfg_delay, then goes to CAPTURE.
  - cfg_delay==0 means the first din_en beat after the edge is captured. That same beat counts as sample 0: the state passes through DELAY in 1 cycle with no sample lost.
- CAPTURE:
  - Each din_en beat at index i does a read-modify-write. The RAM read of addr i is issued in the beat cycle; the write of addr i happens the next cycle.
  - Write value: sign-extended din when shot_cnt==0; otherwise RAM[i]+sign_ext(din).
  - Back-to-back beats hit distinct addresses, so no read/write hazard exists.
  - On the beat where i==cfg_len-1, shot_cnt increments after the final write. If shot_cnt reaches cfg_navg the state goes to OUT; else it returns to ARM.
- Trigger edges in DELAY/CAPTURE are ignored and set trig_miss. Edges in OUT/IDLE are ignored silently.
- Gaps in din_en stall the counters; no timeout applies.
- OUT:
  - Reads addr 0..cfg_len-1 in order.
  - m_valid first rises 2 cycles after entering OUT.
  - Standard valid/ready: m_data/m_valid/m_last hold while m_valid && !m_ready.
  - A 2-entry skid buffer covers RAM latency, so full throughput (1 word/cycle) is sustained with m_ready held high.
  - m_last=1 only with word cfg_len-1.
  - On acceptance of the last word: done pulses one cycle, then the state goes to IDLE.
- Arithmetic: signed, no saturation. ACC_W guarantees no overflow at maximum navg.
- Reset mid-operation: returns to IDLE immediately. A partial record is discarded and the next start overwrites it, because shot 0 writes rather than adds.

Decomposition:
- Shared package echo_avg_pkg holds:
  - state enum: IDLE, ARM, DELAY, CAPTURE, OUT
  - default widths
  - the sign-extension helper function
- One sub-module, echo_avg_ram: simple dual-port RAM, 2^AW x ACC_W, 1-cycle registered read, inferred as block RAM.

Test Plan:
- len=8, navg=1, delay=0; trigger then ramp din=-4..3 → out -4..3, m_last on the 8th word, done pulses once.
- len=4, navg=4, delay=2; each shot din=100,-50,7,8191 after 2 skipped beats → out 400,-200,28,32764.
- len=16, navg=2, din_en toggling 50%, m_ready random 30% → values correct, no dropped or duplicated word, m_data stable while stalled.
- Extra trigger edge mid-CAPTURE → capture unaffected, trig_miss=1; cfg_start during busy → ignored.
- rst asserted mid-CAPTURE of shot 2 of 3 → all outputs 0 next cycle; restart with navg=1, din=5 constant → out all 5 (no stale sums).
- navg=256 with din=-8192 all shots, len=1 → out -2097152 (full-scale negative, no overflow); cfg_len=0 start → busy stays 0.

Source files
------------

// File: rtl/echo_avg_pkg.sv
// Shared definitions for the echo averaging capture block: default widths,
// controller state encoding and the sample sign-extension helper.
package echo_avg_pkg;

  localparam int DW_DEF    = 14;
  localparam int AW_DEF    = 12;
  localparam int AVG_W_DEF = 8;
  localparam int ACC_W_DEF = DW_DEF + AVG_W_DEF;
  localparam int DLY_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    OUT     = 3'd4
  } state_e;

  // Widen a raw ADC sample to accumulator width, preserving its sign.
  function automatic logic [ACC_W_DEF-1:0] sign_ext(input logic [DW_DEF-1:0] v);
    return {{(ACC_W_DEF - DW_DEF){v[DW_DEF-1]}}, v};
  endfunction

endpackage

// File: rtl/echo_avg_ram.sv
// Simple dual-port accumulation RAM: one write port, one read port with a
// single registered read cycle. Written so synthesis maps it to block RAM.
module echo_avg_ram #(
  parameter int AW = 12,
  parameter int DW = 22
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port: store the updated accumulation for one sample slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered read, old data returned on a same-address write.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/echo_avg_capture.sv
// Triggered window capture with coherent multi-shot accumulation in RAM and
// a valid/ready readout of the summed record.
module echo_avg_capture
  import echo_avg_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int AVG_W = AVG_W_DEF,
  parameter int ACC_W = DW + AVG_W,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    din,
  input  logic             din_en,
  input  logic             trig_in,
  input  logic             cfg_start,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [AW:0]      cfg_len,
  input  logic [AVG_W:0]   cfg_navg,
  output logic [ACC_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             trig_miss
);

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  // Controller state and latched configuration
  state_e             state_q, state_d;
  logic [AW:0]        len_q, len_d;
  logic [AVG_W:0]     navg_q, navg_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [AVG_W:0]     shot_q, shot_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic               trig_miss_q, trig_miss_d;
  logic [AW:0]        out_addr_q, out_addr_d;
  logic               done_q, done_d;

  // Trigger synchronizer
  logic sync1_q, sync2_q, sync3_q;
  logic trig_edge_s;

  // Read-modify-write pipeline
  logic               cap_phase_s, cap_beat_s, idx_last_s, len_ok_s;
  logic               wr_pend_q;
  logic [AW-1:0]      wr_addr_q;
  logic [DW-1:0]      wr_din_q;
  logic               wr_first_q;
  logic [ACC_W-1:0]   wr_data_s;

  // RAM access and same-address forwarding
  logic               rd_en_s;
  logic [AW-1:0]      rd_addr_s;
  logic [ACC_W-1:0]   ram_rdata_s, rd_val_s;
  logic               byp_hit_q;
  logic [ACC_W-1:0]   byp_data_q;

  // Readout: in-flight read plus 2-entry skid buffer (entry 0 drives outputs)
  logic               out_rd_s, pop_s;
  logic [2:0]         occ_s;
  logic               rd_pend_q, rd_pend_last_q;
  logic               v0_q, v0_d, v1_q, v1_d;
  logic               l0_q, l0_d, l1_q, l1_d;
  logic [ACC_W-1:0]   d0_q, d0_d, d1_q, d1_d;

  assign trig_edge_s = sync2_q & ~sync3_q;
  assign len_ok_s    = (cfg_len != {(AW+1){1'b0}}) && (cfg_len <= LEN_MAX);
  assign idx_last_s  = ({1'b0, idx_q} == (len_q - {{AW{1'b0}}, 1'b1}));
  assign cap_beat_s  = cap_phase_s & din_en;

  assign pop_s    = v0_q & m_ready;
  assign occ_s    = {2'b00, v0_q} + {2'b00, v1_q} + {2'b00, rd_pend_q} - {2'b00, pop_s};
  assign out_rd_s = (state_q == OUT) && (out_addr_q < len_q) && (occ_s < 3'd2);

  assign rd_en_s   = cap_beat_s | out_rd_s;
  assign rd_addr_s = cap_beat_s ? idx_q : out_addr_q[AW-1:0];
  assign rd_val_s  = byp_hit_q ? byp_data_q : ram_rdata_s;
  assign wr_data_s = wr_first_q ? sign_ext(wr_din_q) : (rd_val_s + sign_ext(wr_din_q));

  echo_avg_ram #(
    .AW (AW),
    .DW (ACC_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_pend_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data_s),
    .re_i    (rd_en_s),
    .raddr_i (rd_addr_s),
    .rdata_o (ram_rdata_s)
  );

  // Bring the asynchronous trigger pin into the clock domain and keep one
  // extra stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= trig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Next-state logic: start/arm/delay sequencing, capture indexing, shot
  // counting and end-of-record detection.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    navg_d      = navg_q;
    dly_d       = dly_q;
    shot_d      = shot_q;
    idx_d       = idx_q;
    dly_cnt_d   = dly_cnt_q;
    trig_miss_d = trig_miss_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;
    cap_phase_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start && len_ok_s) begin
          len_d       = cfg_len;
          navg_d      = (cfg_navg == {(AVG_W+1){1'b0}}) ? {{AVG_W{1'b0}}, 1'b1} : cfg_navg;
          dly_d       = cfg_delay;
          shot_d      = {(AVG_W+1){1'b0}};
          trig_miss_d = 1'b0;
          state_d     = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        if (trig_edge_s) begin
          state_d   = DELAY;
          dly_cnt_d = {DLY_W{1'b0}};
          idx_d     = {AW{1'b0}};
        end else begin
          state_d = ARM;
        end
      end
      DELAY: begin
        if (trig_edge_s) begin
          trig_miss_d = 1'b1;
        end else begin
          trig_miss_d = trig_miss_q;
        end
        // Once the skip count is met, this cycle already behaves as CAPTURE
        // so a beat arriving now becomes sample 0.
        if (dly_cnt_q == dly_q) begin
          state_d     = CAPTURE;
          cap_phase_s = 1'b1;
        end else if (din_en) begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end else begin
          dly_cnt_d = dly_cnt_q;
        end
      end
      CAPTURE: begin
        if (trig_edge_s) begin
          trig_miss_d = 1'b1;
        end else begin
          trig_miss_d = trig_miss_q;
        end
        cap_phase_s = 1'b1;
      end
      OUT: begin
        if (out_rd_s) begin
          out_addr_d = out_addr_q + (AW+1)'(1);
        end else begin
          out_addr_d = out_addr_q;
        end
        if (pop_s && l0_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cap_beat_s) begin
      if (idx_last_s) begin
        idx_d      = {AW{1'b0}};
        shot_d     = shot_q + (AVG_W+1)'(1);
        out_addr_d = {(AW+1){1'b0}};
        if ((shot_q + (AVG_W+1)'(1)) == navg_q) begin
          state_d = OUT;
        end else begin
          state_d = ARM;
        end
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= {(AW+1){1'b0}};
      navg_q      <= {(AVG_W+1){1'b0}};
      dly_q       <= {DLY_W{1'b0}};
      shot_q      <= {(AVG_W+1){1'b0}};
      idx_q       <= {AW{1'b0}};
      dly_cnt_q   <= {DLY_W{1'b0}};
      trig_miss_q <= 1'b0;
      out_addr_q  <= {(AW+1){1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      navg_q      <= navg_d;
      dly_q       <= dly_d;
      shot_q      <= shot_d;
      idx_q       <= idx_d;
      dly_cnt_q   <= dly_cnt_d;
      trig_miss_q <= trig_miss_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  // Capture pipeline: remember the beat so its write lands the cycle after
  // the read, and forward a write that collides with a read of the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= {AW{1'b0}};
      wr_din_q   <= {DW{1'b0}};
      wr_first_q <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= {ACC_W{1'b0}};
    end else begin
      wr_pend_q  <= cap_beat_s;
      wr_addr_q  <= idx_q;
      wr_din_q   <= din;
      wr_first_q <= (shot_q == {(AVG_W+1){1'b0}});
      byp_hit_q  <= wr_pend_q && rd_en_s && (wr_addr_q == rd_addr_s);
      byp_data_q <= wr_data_s;
    end
  end

  // Skid buffer next state: pop the head on acceptance, then append the word
  // returning from RAM behind whatever remains.
  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    l0_d = l0_q;
    l1_d = l1_q;
    d0_d = d0_q;
    d1_d = d1_q;
    if (pop_s) begin
      if (v1_q) begin
        d0_d = d1_q;
        l0_d = l1_q;
        v1_d = 1'b0;
        l1_d = 1'b0;
      end else begin
        v0_d = 1'b0;
        l0_d = 1'b0;
      end
    end else begin
      v0_d = v0_q;
    end
    if (rd_pend_q) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        d0_d = rd_val_s;
        l0_d = rd_pend_last_q;
      end else begin
        v1_d = 1'b1;
        d1_d = rd_val_s;
        l1_d = rd_pend_last_q;
      end
    end else begin
      v1_d = v1_d;
    end
  end

  // Readout registers: in-flight read tag and the skid buffer entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      v0_q           <= 1'b0;
      v1_q           <= 1'b0;
      l0_q           <= 1'b0;
      l1_q           <= 1'b0;
      d0_q           <= {ACC_W{1'b0}};
      d1_q           <= {ACC_W{1'b0}};
    end else begin
      rd_pend_q      <= out_rd_s;
      rd_pend_last_q <= out_rd_s && (out_addr_q == (len_q - {{AW{1'b0}}, 1'b1}));
      v0_q           <= v0_d;
      v1_q           <= v1_d;
      l0_q           <= l0_d;
      l1_q           <= l1_d;
      d0_q           <= d0_d;
      d1_q           <= d1_d;
    end
  end

  assign m_data    = d0_q;
  assign m_valid   = v0_q;
  assign m_last    = l0_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign trig_miss = trig_miss_q;

endmodule

// File: tb/tb_echo_avg_capture.sv
// Directed testbench for echo_avg_capture: drives triggered shots, collects
// the averaged record and compares against hand-computed sums.
module tb_echo_avg_capture;

  localparam int DW    = 14;
  localparam int AW    = 12;
  localparam int AVG_W = 8;
  localparam int ACC_W = DW + AVG_W;
  localparam int DLY_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DW-1:0]    din = '0;
  logic             din_en = 1'b0;
  logic             trig_in = 1'b0;
  logic             cfg_start = 1'b0;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic [AW:0]      cfg_len = '0;
  logic [AVG_W:0]   cfg_navg = '0;
  logic [ACC_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic             busy;
  logic             done;
  logic             trig_miss;

  int     n_vec  = 0;
  int     n_miss = 0;
  longint exp_q[$];

  echo_avg_capture dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_en    (din_en),
    .trig_in   (trig_in),
    .cfg_start (cfg_start),
    .cfg_delay (cfg_delay),
    .cfg_len   (cfg_len),
    .cfg_navg  (cfg_navg),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .trig_miss (trig_miss)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len, input int navg, input int dly);
    cfg_len   = (AW+1)'(len);
    cfg_navg  = (AVG_W+1)'(navg);
    cfg_delay = DLY_W'(dly);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    repeat (4) tick();
    trig_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic beat(input int v, input bit gap);
    din    = DW'(v);
    din_en = 1'b1;
    tick();
    din_en = 1'b0;
    if (gap) tick();
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_valid"}, longint'(m_valid), 0);
    check_val({tag, "_last"},  longint'(m_last), 0);
    check_val({tag, "_busy"},  longint'(busy), 0);
    check_val({tag, "_done"},  longint'(done), 0);
    check_val({tag, "_miss"},  longint'(trig_miss), 0);
    check_val({tag, "_data"},  longint'($signed(m_data)), 0);
  endtask

  // Drain one record, comparing each accepted word with exp_q in order.
  task automatic collect(input string tag, input int pct);
    int               n = exp_q.size();
    int               got = 0;
    int               cyc = 0;
    int               dn = 0;
    bit               stall = 1'b0;
    logic [ACC_W-1:0] prev_d = '0;
    logic             prev_l = 1'b0;
    while (got < n && cyc < 3000) begin
      if (done) dn++;
      if (stall) begin
        check_val({tag, "_hold_valid"}, longint'(m_valid), 1);
        check_val({tag, "_hold_data"}, longint'($signed(m_data)), longint'($signed(prev_d)));
        check_val({tag, "_hold_last"}, longint'(m_last), longint'(prev_l));
      end
      m_ready = ($urandom_range(99) < pct);
      if (m_valid && m_ready) begin
        check_val({tag, "_data"}, longint'($signed(m_data)), exp_q[got]);
        check_val({tag, "_last"}, longint'(m_last), (got == n - 1) ? 1 : 0);
        got++;
      end
      stall  = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    check_val({tag, "_count"}, longint'(got), longint'(n));
    check_val({tag, "_early_done"}, longint'(dn), 0);
    check_val({tag, "_done"}, longint'(done), 1);
    tick();
    check_val({tag, "_done_once"}, longint'(done), 0);
    check_val({tag, "_idle"}, longint'(busy), 0);
    check_val({tag, "_no_extra"}, longint'(m_valid), 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Single shot ramp, no delay
    start(8, 1, 0);
    check_val("t1_busy", longint'(busy), 1);
    pulse_trig();
    for (int i = -4; i <= 3; i++) begin
      beat(i, 1'b0);
      exp_q.push_back(longint'(i));
    end
    collect("t1", 100);

    // Four shots, delay of two beats, junk beats while armed
    start(4, 4, 2);
    for (int s = 0; s < 4; s++) begin
      beat(1234, 1'b0);
      beat(-777, 1'b0);
      pulse_trig();
      beat(111, 1'b0);
      beat(222, 1'b0);
      beat(100, 1'b0);
      beat(-50, 1'b0);
      beat(7, 1'b0);
      beat(8191, 1'b0);
    end
    exp_q.push_back(400);
    exp_q.push_back(-200);
    exp_q.push_back(28);
    exp_q.push_back(32764);
    collect("t2", 100);

    // Two shots, 50% din_en duty, 30% m_ready
    start(16, 2, 0);
    pulse_trig();
    for (int i = 0; i < 16; i++) beat(3 * i - 20, 1'b1);
    pulse_trig();
    for (int i = 0; i < 16; i++) beat(1000 - 7 * i, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(longint'(980 - 4 * i));
    collect("t3", 30);

    // Extra trigger mid-capture and a start while busy
    start(4, 1, 0);
    check_val("t4_miss_clear", longint'(trig_miss), 0);
    pulse_trig();
    beat(1, 1'b0);
    beat(2, 1'b0);
    pulse_trig();
    check_val("t4_miss_set", longint'(trig_miss), 1);
    start(1, 1, 0);
    beat(3, 1'b0);
    beat(4, 1'b0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(longint'(i));
    collect("t4", 100);
    check_val("t4_miss_sticky", longint'(trig_miss), 1);

    // Reset during shot 2 of 3, then a clean single-shot restart
    start(8, 3, 0);
    check_val("t5_miss_clear", longint'(trig_miss), 0);
    pulse_trig();
    for (int i = 0; i < 8; i++) beat(9, 1'b0);
    pulse_trig();
    for (int i = 0; i < 4; i++) beat(9, 1'b0);
    pulse_trig();
    check_val("t5_miss_set", longint'(trig_miss), 1);
    rst = 1'b1;
    tick();
    check_quiet("t5_rst");
    rst = 1'b0;
    tick();
    start(8, 1, 0);
    pulse_trig();
    for (int i = 0; i < 8; i++) begin
      beat(5, 1'b0);
      exp_q.push_back(5);
    end
    collect("t5", 100);

    // Full-scale negative over 256 shots, single-sample window
    start(1, 256, 0);
    for (int s = 0; s < 256; s++) begin
      pulse_trig();
      beat(-8192, 1'b0);
    end
    exp_q.push_back(-2097152);
    collect("t6", 100);

    // Illegal window lengths are refused
    start(0, 1, 0);
    check_val("t7_len0_busy", longint'(busy), 0);
    tick();
    check_val("t7_len0_busy2", longint'(busy), 0);
    start(4097, 1, 0);
    check_val("t7_len4097_busy", longint'(busy), 0);

    // navg of zero acts as a single shot
    start(2, 0, 0);
    pulse_trig();
    beat(-3, 1'b0);
    beat(6, 1'b0);
    exp_q.push_back(-3);
    exp_q.push_back(6);
    collect("t8", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
